// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;
  localparam int STALL_W = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search, first set req bit after last.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] win
);
  logic [W-1:0] idx;
  // Scan downward so the candidate closest to last+1 is written last and wins.
  always_comb begin
    found = |req;
    win = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last) + k) % N);
      if (req[idx]) win = idx;
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port among NUM_REQ producers.
// Define ARB_STALL_CNT_EN to build the saturating full-stall counter on stall_cnt.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      fifo_wn,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [IW-1:0]             grant_id,
  output logic                      busy,
  output logic [STALL_W-1:0]        stall_cnt
);
  localparam int BW = $clog2(BURST_MAX + 1);
  arb_state_t state;
  logic [IW-1:0] last_winner, win;
  logic [BW-1:0] beat_cnt;
  logic found, accept, done;
  rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .req  (req),
    .last (last_winner),
    .found(found),
    .win  (win)
  );
  assign busy = state == ARB_XFER;
  assign accept = busy & req[grant_id] & ~fifo_full;
  // Abandon only counts when nothing was accepted this cycle.
  assign done = accept ? (req_last[grant_id] | (beat_cnt == BW'(BURST_MAX - 1)))
                       : (busy & ~req[grant_id]);
  assign fifo_wn = accept;
  assign ack = accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign fifo_din = busy ? req_data[int'(grant_id)*DATA_W +: DATA_W] : '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
      grant_id <= '0;
      last_winner <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else if (!busy) begin
      if (found) begin
        state <= ARB_XFER;
        grant_id <= win;
        beat_cnt <= '0;
      end
    end else if (done) begin
      state <= ARB_IDLE;
      last_winner <= grant_id;
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`ifdef ARB_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_q <= '0;
    else if (busy & req[grant_id] & fifo_full & ~&stall_q) stall_q <= stall_q + 1'b1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a queue-based model.
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, BM = 4;
`ifdef ARB_STALL_CNT_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, fifo_full = 1'b0;
  logic [N-1:0] req = '0, req_last = '0, ack;
  logic [N*DW-1:0] req_data = '0;
  logic fifo_wn, busy;
  logic [DW-1:0] fifo_din;
  logic [1:0] grant_id;
  logic [15:0] stall_cnt;
  int checks = 0, failures = 0, cyc = 0;
  int owner = -1, lw = N - 1, beats = 0, stall = 0;
  logic [8:0] q[N][$];
  int wlog[$];
  int e[$];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .fifo_full(fifo_full), .fifo_wn(fifo_wn), .fifo_din(fifo_din),
    .grant_id(grant_id), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() != 0) begin
        req[i] = 1'b1;
        req_last[i] = q[i][0][8];
        req_data[i*DW +: DW] = q[i][0][7:0];
      end else begin
        req[i] = 1'b0;
        req_last[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic push(input int p, input int n, input int d0, input bit with_last);
    for (int k = 0; k < n; k++) q[p].push_back({with_last && k == n - 1, 8'(d0 + k)});
  endtask

  task automatic cycle();
    int o;
    bit acc;
    logic [7:0] din_e;
    apply();
    #2;
    o = owner;
    acc = 1'b0;
    din_e = '0;
    if (o >= 0) begin
      acc = req[o] && !fifo_full;
      din_e = req_data[o*DW +: DW];
    end
    chk("busy", busy, o >= 0);
    chk("wn", fifo_wn, acc);
    chk("ack", ack, acc ? (1 << o) : 0);
    chk("din", fifo_din, din_e);
    chk("stall", stall_cnt, SE ? stall : 0);
    if (o >= 0) chk("grant", grant_id, o);
    if (fifo_wn) wlog.push_back(cyc * 65536 + int'(grant_id) * 256 + int'(fifo_din));
    if (o >= 0 && req[o] && fifo_full && stall < 65535) stall++;
    @(posedge clock);
    if (o < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (req[(lw + k) % N]) begin
          owner = (lw + k) % N;
          beats = 0;
          break;
        end
      end
    end else if (acc) begin
      beats++;
      void'(q[o].pop_front());
      if (req_last[o] || beats == BM) begin
        lw = o;
        owner = -1;
      end
    end else if (!req[o]) begin
      lw = o;
      owner = -1;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic start();
    wlog.delete();
    cyc = 0;
  endtask

  task automatic cmp(input string tag, input bit ids_only);
    chk({tag, "_len"}, wlog.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk(tag, i < wlog.size() ? (ids_only ? (wlog[i] >> 8) & 255 : wlog[i]) : -1, e[i]);
  endtask

  task automatic do_reset();
    apply();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wn", fifo_wn, 0);
    chk("rst_ack", ack, 0);
    owner = -1;
    lw = N - 1;
    beats = 0;
    stall = 0;
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #2;
    chk("init_busy", busy, 0);
    chk("init_wn", fifo_wn, 0);
    chk("init_ack", ack, 0);
    chk("init_din", fifo_din, 0);
    chk("init_stall", stall_cnt, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    // single producer, three beats
    start();
    push(0, 3, 8'hA1, 1);
    run(5);
    e = '{1*65536 + 8'hA1, 2*65536 + 8'hA2, 3*65536 + 8'hA3};
    cmp("single", 0);
    // round robin from a fresh reset
    do_reset();
    start();
    push(0, 1, 8'h10, 1);
    push(1, 1, 8'h11, 1);
    push(2, 1, 8'h12, 1);
    push(3, 1, 8'h13, 1);
    push(0, 1, 8'h50, 1);
    run(11);
    e = '{1*65536 + 8'h10, 3*65536 + 256 + 8'h11, 5*65536 + 512 + 8'h12,
          7*65536 + 768 + 8'h13, 9*65536 + 8'h50};
    cmp("rr", 0);
    // burst cap with a competing producer
    start();
    push(2, 10, 8'h20, 0);
    cycle();
    push(1, 2, 8'h50, 1);
    run(17);
    e = '{2, 2, 2, 2, 1, 1, 2, 2, 2, 2, 2, 2};
    cmp("burst", 1);
    // five cycles of backpressure mid-burst
    start();
    push(3, 6, 8'h30, 1);
    run(3);
    fifo_full = 1'b1;
    run(5);
    fifo_full = 1'b0;
    run(6);
    e = '{1*65536 + 768 + 8'h30, 2*65536 + 768 + 8'h31, 8*65536 + 768 + 8'h32,
          9*65536 + 768 + 8'h33, 11*65536 + 768 + 8'h34, 12*65536 + 768 + 8'h35};
    cmp("full", 0);
    chk("full_stall", stall_cnt, SE ? 5 : 0);
    // owner abandons its grant
    start();
    push(1, 3, 8'h40, 0);
    run(2);
    q[1].delete();
    push(0, 1, 8'h70, 1);
    push(2, 1, 8'h60, 1);
    run(6);
    e = '{1*65536 + 256 + 8'h40, 4*65536 + 512 + 8'h60, 6*65536 + 8'h70};
    cmp("abandon", 0);
    // asynchronous reset mid-burst
    start();
    push(0, 4, 8'h80, 1);
    run(2);
    push(3, 1, 8'h90, 1);
    do_reset();
    start();
    run(7);
    e = '{1*65536 + 8'h81, 2*65536 + 8'h82, 3*65536 + 8'h83, 5*65536 + 768 + 8'h90};
    cmp("reset_mid", 0);
    // randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() == 0 && $urandom % 4 == 0)
          push(i, $urandom_range(1, 6), $urandom % 256, $urandom % 4 != 0);
      if ($urandom % 50 == 0) q[$urandom % N].delete();
      fifo_full = ($urandom % 4 == 0);
      cycle();
    end
    for (int i = 0; i < N; i++) q[i].delete();
    fifo_full = 1'b0;
    run(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
